// File: rtl/led_sequencer.sv
// led_sequencer: programmable-rate LED pattern generator (shift, bounce, blink, count).
// Build with LED_PWM_EN defined to add a pwm_duty brightness input that gates the LED drive.
module led_sequencer #(
  parameter int LED_NUM   = 8,
  parameter int DIV_W     = 24,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic               sys_clk,
  input  logic               sys_rst_n,
  input  logic               enable,
  input  logic [1:0]         mode,
  input  logic [DIV_W-1:0]   div_val,
`ifdef LED_PWM_EN
  input  logic [7:0]         pwm_duty,
`endif
  output logic [LED_NUM-1:0] LED,
  output logic               tick,
  output logic               wrap
);

  // state (mode_q) | meaning
  // M_SHIFT        | one-hot walks position 0 -> LED_NUM-1, then restarts at 0
  // M_BOUNCE       | one-hot walks up to LED_NUM-1 and back down to 0
  // M_BLINK        | all LEDs toggle between on and off
  // M_COUNT        | LED shows a binary counter
  typedef enum logic [1:0] {
    M_SHIFT  = 2'd0,
    M_BOUNCE = 2'd1,
    M_BLINK  = 2'd2,
    M_COUNT  = 2'd3
  } mode_e;

  localparam int POS_W = (LED_NUM > 1) ? $clog2(LED_NUM) : 1;
  localparam logic [POS_W-1:0] POS_LAST = POS_W'(LED_NUM - 1);

  mode_e              mode_q, mode_d, mode_in;
  logic [DIV_W-1:0]   pre_q, pre_d, period_m1;
  logic [POS_W-1:0]   pos_q, pos_d;
  logic               dir_q, dir_d;
  logic               phase_q, phase_d;
  logic               shown_q, shown_d;
  logic [LED_NUM-1:0] cnt_q, cnt_d;
  logic [LED_NUM-1:0] pat_q, pat_d, onehot;
  logic               tick_int, wrap_d;

  assign mode_in   = mode_e'(mode);
  assign period_m1 = (div_val == '0) ? '0 : div_val - DIV_W'(1);
  assign tick_int  = enable && (pre_q == period_m1);

  // shown_q marks that the current position is already on the LEDs; the first
  // tick after reset displays step 0 instead of advancing past it.
  always_comb begin
    pre_d   = pre_q;
    mode_d  = mode_q;
    pos_d   = pos_q;
    dir_d   = dir_q;
    phase_d = phase_q;
    shown_d = shown_q;
    cnt_d   = cnt_q;
    wrap_d  = 1'b0;
    if (enable) pre_d = tick_int ? '0 : pre_q + DIV_W'(1);
    if (tick_int) begin
      shown_d = 1'b1;
      if (mode_in != mode_q) begin
        mode_d  = mode_in;
        pos_d   = '0;
        dir_d   = 1'b0;
        phase_d = 1'b1;
        cnt_d   = '0;
      end else if (shown_q) begin
        unique case (mode_q)
          M_SHIFT: begin
            pos_d  = (pos_q == POS_LAST) ? '0 : pos_q + POS_W'(1);
            wrap_d = (pos_q == POS_LAST);
          end
          M_BOUNCE: begin
            if (!dir_q) begin
              if (pos_q == POS_LAST) begin
                pos_d = pos_q - POS_W'(1);
                dir_d = 1'b1;
              end else begin
                pos_d = pos_q + POS_W'(1);
              end
            end else begin
              if (pos_q == '0) begin
                pos_d = pos_q + POS_W'(1);
                dir_d = 1'b0;
              end else begin
                pos_d = pos_q - POS_W'(1);
              end
            end
            wrap_d = (pos_d == '0);
          end
          M_BLINK: begin
            phase_d = ~phase_q;
            wrap_d  = ~phase_q;
          end
          M_COUNT: begin
            cnt_d  = cnt_q + LED_NUM'(1);
            wrap_d = (cnt_q == '1);
          end
        endcase
      end
    end
  end

  always_comb begin
    onehot = '0;
    for (int i = 0; i < LED_NUM; i++)
      onehot[i] = ((MSB_FIRST ? (LED_NUM - 1 - i) : i) == int'(pos_d));
  end

  always_comb begin
    pat_d = pat_q;
    if (tick_int) begin
      unique case (mode_d)
        M_SHIFT, M_BOUNCE: pat_d = onehot;
        M_BLINK:           pat_d = {LED_NUM{phase_d}};
        M_COUNT:           pat_d = cnt_d;
      endcase
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      pre_q   <= '0;
      mode_q  <= M_SHIFT;
      pos_q   <= '0;
      dir_q   <= 1'b0;
      phase_q <= 1'b1;
      shown_q <= 1'b0;
      cnt_q   <= '0;
      pat_q   <= '0;
      tick    <= 1'b0;
      wrap    <= 1'b0;
    end else begin
      pre_q   <= pre_d;
      mode_q  <= mode_d;
      pos_q   <= pos_d;
      dir_q   <= dir_d;
      phase_q <= phase_d;
      shown_q <= shown_d;
      cnt_q   <= cnt_d;
      pat_q   <= pat_d;
      tick    <= tick_int;
      wrap    <= wrap_d;
    end
  end

`ifdef LED_PWM_EN
  // 255-step period so that duty 255 is fully on and duty 0 fully off.
  logic [7:0]         pwm_cnt;
  logic [LED_NUM-1:0] led_q;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      pwm_cnt <= '0;
      led_q   <= '0;
    end else begin
      pwm_cnt <= (pwm_cnt == 8'd254) ? '0 : pwm_cnt + 8'd1;
      led_q   <= pat_d & {LED_NUM{pwm_cnt < pwm_duty}};
    end
  end

  assign LED = led_q;
`else
  assign LED = pat_q;
`endif

endmodule

// File: tb/tb_led_sequencer.sv
// Directed bench for led_sequencer: an 8-LED/24-bit instance for the pattern checks and
// a 4-LED/4-bit instance for count mode, div_val=0 and the lowered-divider wrap.
module tb_led_sequencer;

  logic        sys_clk;
  logic        sys_rst_n;
  logic        enable, en4;
  logic [1:0]  mode, mode4;
  logic [23:0] div_val;
  logic [3:0]  div4;
  logic [7:0]  pwm_duty, pwm_duty4;
  logic [7:0]  LED;
  logic [3:0]  LED4;
  logic        tick, wrap, tick4, wrap4;

  int n_cmp = 0;
  int n_err = 0;

  led_sequencer #(.LED_NUM(8), .DIV_W(24), .MSB_FIRST(1'b1)) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .enable    (enable),
    .mode      (mode),
    .div_val   (div_val),
`ifdef LED_PWM_EN
    .pwm_duty  (pwm_duty),
`endif
    .LED       (LED),
    .tick      (tick),
    .wrap      (wrap)
  );

  led_sequencer #(.LED_NUM(4), .DIV_W(4), .MSB_FIRST(1'b1)) dut4 (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .enable    (en4),
    .mode      (mode4),
    .div_val   (div4),
`ifdef LED_PWM_EN
    .pwm_duty  (pwm_duty4),
`endif
    .LED       (LED4),
    .tick      (tick4),
    .wrap      (wrap4)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_tick(input string tag, input int max_cyc);
    int k;
    k = 0;
    do begin
      step();
      k++;
    end while (tick !== 1'b1 && k < max_cyc);
    n_cmp++;
    assert (tick === 1'b1) else begin
      n_err++;
      $error("FAIL %s tick timeout observed=%b expected=1", tag, tick);
    end
  endtask

  initial begin
    logic [7:0] exp8;
    int         p;
    int         hi;

    sys_rst_n = 1'b0;
    enable    = 1'b1;
    mode      = 2'd0;
    div_val   = 24'd4;
    pwm_duty  = 8'd255;
    en4       = 1'b0;
    mode4     = 2'd3;
    div4      = 4'd0;
    pwm_duty4 = 8'd255;

    // reset state
    #12;
    chk("rst_led", LED, 8'h00);
    chk("rst_tick", tick, 1'b0);
    chk("rst_wrap", wrap, 1'b0);
    chk("rst_led4", LED4, 4'h0);
    #10;
    sys_rst_n = 1'b1;

    // SHIFT, div_val=4: LED dark for the first P-1 edges, then 0x80 on the 4th
    chk("shift_pre_led", LED, 8'h00);
    for (int c = 0; c < 3; c++) begin
      step();
      chk("shift_first_dark", LED, 8'h00);
      chk("shift_first_notick", tick, 1'b0);
    end
    step();
    chk("shift_first_led", LED, 8'h80);
    chk("shift_first_tick", tick, 1'b1);
    chk("shift_first_wrap", wrap, 1'b0);
    for (int k = 1; k <= 8; k++) begin
      exp8 = 8'h80 >> (k % 8);
      for (int c = 0; c < 3; c++) begin
        step();
        chk("shift_hold_tick", tick, 1'b0);
        chk("shift_hold_wrap", wrap, 1'b0);
      end
      step();
      chk("shift_led", LED, exp8);
      chk("shift_tick", tick, 1'b1);
      chk("shift_wrap", wrap, (k == 8) ? 1'b1 : 1'b0);
    end

    // BOUNCE, div_val=1: tick every cycle, endpoints shown once
    mode    = 2'd1;
    div_val = 24'd1;
    for (int s = 0; s <= 15; s++) begin
      p = (s <= 7) ? s : ((s <= 14) ? 14 - s : s - 14);
      exp8 = 8'h80 >> p;
      step();
      chk("bounce_led", LED, exp8);
      chk("bounce_tick", tick, 1'b1);
      chk("bounce_wrap", wrap, (s == 14) ? 1'b1 : 1'b0);
    end

    // SHIFT up to 0x10, then switch to BLINK
    mode    = 2'd0;
    div_val = 24'd2;
    exp8 = 8'h80;
    for (int k = 0; k < 4; k++) begin
      wait_tick("shift2_tick", 8);
      chk("shift2_led", LED, exp8);
      chk("shift2_wrap", wrap, 1'b0);
      exp8 = exp8 >> 1;
    end
    mode = 2'd2;
    step();
    chk("blink_sw_hold_led", LED, 8'h10);
    chk("blink_sw_hold_tick", tick, 1'b0);
    step();
    chk("blink_sw_led", LED, 8'hFF);
    chk("blink_sw_tick", tick, 1'b1);
    chk("blink_sw_wrap", wrap, 1'b0);
    step();
    step();
    chk("blink_off_led", LED, 8'h00);
    chk("blink_off_wrap", wrap, 1'b0);
    step();
    step();
    chk("blink_on_led", LED, 8'hFF);
    chk("blink_on_wrap", wrap, 1'b1);

    // COUNT, div_val=4, with a 10-cycle enable freeze mid-period
    mode    = 2'd3;
    div_val = 24'd4;
    wait_tick("count_sw_tick", 10);
    chk("count_sw_led", LED, 8'h00);
    chk("count_sw_wrap", wrap, 1'b0);
    wait_tick("count1_tick", 10);
    chk("count1_led", LED, 8'h01);
    step();
    step();
    enable = 1'b0;
    for (int c = 0; c < 10; c++) begin
      step();
      chk("freeze_led", LED, 8'h01);
      chk("freeze_tick", tick, 1'b0);
    end
    enable = 1'b1;
    step();
    chk("resume_early_tick", tick, 1'b0);
    step();
    chk("resume_tick", tick, 1'b1);
    chk("resume_led", LED, 8'h02);

    // reset pulse in the middle of BOUNCE
    mode    = 2'd1;
    div_val = 24'd1;
    step();
    chk("bounce2_led0", LED, 8'h80);
    step();
    step();
    chk("bounce2_led2", LED, 8'h20);
    #3;
    sys_rst_n = 1'b0;
    #1;
    chk("midrst_led", LED, 8'h00);
    chk("midrst_tick", tick, 1'b0);
    chk("midrst_wrap", wrap, 1'b0);
    step();
    sys_rst_n = 1'b1;
    step();
    chk("postrst_led", LED, 8'h80);
    chk("postrst_tick", tick, 1'b1);
    chk("postrst_wrap", wrap, 1'b0);

    // 4-LED COUNT with div_val=0 (ticks every cycle)
    en4 = 1'b1;
    step();
    chk("c4_sw_led", LED4, 4'h0);
    chk("c4_sw_tick", tick4, 1'b1);
    chk("c4_sw_wrap", wrap4, 1'b0);
    for (int v = 1; v <= 16; v++) begin
      step();
      chk("c4_led", LED4, v % 16);
      chk("c4_tick", tick4, 1'b1);
      chk("c4_wrap", wrap4, (v == 16) ? 1'b1 : 1'b0);
    end

    // lowering div_val below the running prescaler: count through 15, no tick on the wrap
    div4 = 4'd8;
    for (int c = 0; c < 5; c++) step();
    chk("low_pre_tick", tick4, 1'b0);
    div4 = 4'd2;
    for (int c = 0; c < 12; c++) begin
      step();
      chk("low_notick", tick4, 1'b0);
      chk("low_hold_led", LED4, 4'h0);
    end
    step();
    chk("low_tick", tick4, 1'b1);
    chk("low_led", LED4, 4'h1);

`ifdef LED_PWM_EN
    mode    = 2'd2;
    div_val = 24'd2;
    wait_tick("pwm_sw_tick", 8);
    chk("pwm_sw_led", LED, 8'hFF);
    div_val  = 24'd4000;
    pwm_duty = 8'd64;
    step();
    hi = 0;
    for (int c = 0; c < 255; c++) begin
      step();
      if (LED[3]) hi++;
    end
    chk("pwm_duty64", hi, 64);
    pwm_duty = 8'd255;
    step();
    hi = 0;
    for (int c = 0; c < 255; c++) begin
      step();
      if (LED == 8'hFF) hi++;
    end
    chk("pwm_duty255", hi, 255);
    pwm_duty = 8'd0;
    step();
    hi = 0;
    for (int c = 0; c < 255; c++) begin
      step();
      if (LED != 8'h00) hi++;
    end
    chk("pwm_duty0", hi, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
